// File: rtl/AHB_package.sv
// Shared AHB types: transfer encoding and slave-arbiter state, plus small
// transfer-type predicates used by the arbiter.
package AHB_package;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_GRANT  = 2'b01,
        ARB_SWITCH = 2'b10
    } arb_state_type;

    // A beat moves the burst forward only for NONSEQ/SEQ.
    function automatic logic is_active_beat(htrans_type t);
        return (t == NONSEQ) || (t == SEQ);
    endfunction

    // Safe points to take the bus away: no burst in flight on the next beat.
    function automatic logic is_burst_boundary(htrans_type t);
        return (t == IDLE) || (t == NONSEQ);
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational prioritised picker: first set request scanning upward from
// start_idx with wrap-around, or lowest index when rr_enable is low.
module ahb_rr_picker #(
    parameter int REQ_NUM   = 3,
    parameter int IDX_WIDTH = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic [REQ_NUM-1:0]   req,
    input  logic [IDX_WIDTH-1:0] start_idx,
    input  logic                 rr_enable,
    output logic [REQ_NUM-1:0]   grant,
    output logic [IDX_WIDTH-1:0] grant_idx
);

    always_comb begin
        int   base;
        int   cand;
        logic found;
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        base      = rr_enable ? int'(start_idx) : 0;
        cand      = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            cand = base + i;
            if (cand >= REQ_NUM) begin
                cand = cand - REQ_NUM;
            end
            for (int j = 0; j < REQ_NUM; j++) begin
                if (!found && (j == cand) && req[j]) begin
                    found     = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = IDX_WIDTH'(j);
                end
            end
        end
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: grants one requesting master at a time and makes a
// long-running owner yield at a transfer boundary when others are waiting.
module ahb_slave_arbiter
    import AHB_package::*;
#(
    parameter int SLAVE_X_MASTER_NUM = 3,
    parameter bit RR_ENABLE          = 1'b1,
    parameter int MAX_HOLD           = 16,
    parameter int MIDX_WIDTH         = $clog2(SLAVE_X_MASTER_NUM)
) (
    input  logic                                hclk,
    input  logic                                hreset,
    input  logic [SLAVE_X_MASTER_NUM-1:0]       hreq,
    input  logic [SLAVE_X_MASTER_NUM-1:0][1:0]  htrans,
    input  logic                                hready,
    output logic [SLAVE_X_MASTER_NUM-1:0]       hgrant,
    output logic [SLAVE_X_MASTER_NUM-1:0]       hlast,
    output logic                                hsel,
    output logic [MIDX_WIDTH-1:0]               hmaster
);

    localparam int                     N         = SLAVE_X_MASTER_NUM;
    localparam int                     CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]       HOLD_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0]       HOLD_WARN = CNT_W'(MAX_HOLD - 1);
    localparam logic [MIDX_WIDTH-1:0]  LAST_IDX  = MIDX_WIDTH'(N - 1);
    localparam logic [N-1:0]           ONE_HOT0  = N'(1);

    arb_state_type          state, state_nxt;
    logic [CNT_W-1:0]       hold_cnt, hold_cnt_nxt;
    logic [MIDX_WIDTH-1:0]  last_owner, last_owner_nxt;
    logic [MIDX_WIDTH-1:0]  hmaster_nxt;
    logic [N-1:0]           hgrant_nxt, hlast_nxt;

    logic [MIDX_WIDTH-1:0]  pick_start, pick_idx;
    logic [N-1:0]           pick_grant;
    logic [N-1:0]           owner_oh;
    htrans_type             owner_trans;
    logic                   owner_req, others, beat, boundary, release_now;

    assign owner_oh    = ONE_HOT0 << hmaster;
    assign owner_trans = htrans_type'(htrans[hmaster]);
    assign owner_req   = hreq[hmaster];
    assign others      = |(hreq & ~owner_oh);
    assign beat        = hready && is_active_beat(owner_trans);
    assign boundary    = is_burst_boundary(owner_trans);

    // Voluntary release wins over a forced one; both wait for hready.
    assign release_now = hready &&
                         (!owner_req || ((hold_cnt == HOLD_MAX) && others && boundary));

    assign pick_start  = (last_owner == LAST_IDX) ? '0 : last_owner + MIDX_WIDTH'(1);

    ahb_rr_picker #(
        .REQ_NUM   (N),
        .IDX_WIDTH (MIDX_WIDTH)
    ) u_picker (
        .req       (hreq),
        .start_idx (pick_start),
        .rr_enable (RR_ENABLE),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    always_comb begin
        state_nxt      = state;
        hold_cnt_nxt   = hold_cnt;
        last_owner_nxt = last_owner;
        hmaster_nxt    = hmaster;
        hgrant_nxt     = hgrant;
        hlast_nxt      = hlast;

        case (state)
            ARB_IDLE, ARB_SWITCH: begin
                hgrant_nxt   = '0;
                hlast_nxt    = '0;
                hold_cnt_nxt = '0;
                state_nxt    = ARB_IDLE;
                if (|hreq) begin
                    state_nxt   = ARB_GRANT;
                    hgrant_nxt  = pick_grant;
                    hmaster_nxt = pick_idx;
                end
            end

            ARB_GRANT: begin
                if (beat && (hold_cnt != HOLD_MAX)) begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end
                if (release_now) begin
                    // last_owner moves at entry to ARB_SWITCH so the pick made
                    // during the dead cycle already starts after the releaser.
                    state_nxt      = ARB_SWITCH;
                    hgrant_nxt     = '0;
                    hlast_nxt      = '0;
                    hold_cnt_nxt   = '0;
                    last_owner_nxt = hmaster;
                end else if (others && (hold_cnt_nxt >= HOLD_WARN)) begin
                    hlast_nxt = owner_oh;
                end
            end

            default: begin
                state_nxt  = ARB_IDLE;
                hgrant_nxt = '0;
                hlast_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (hreset) begin
            state      <= ARB_IDLE;
            hold_cnt   <= '0;
            last_owner <= LAST_IDX;
            hmaster    <= '0;
            hgrant     <= '0;
            hlast      <= '0;
            hsel       <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            last_owner <= last_owner_nxt;
            hmaster    <= hmaster_nxt;
            hgrant     <= hgrant_nxt;
            hlast      <= hlast_nxt;
            hsel       <= |hgrant_nxt;
        end
    end

endmodule
